// File: rtl/if_id_inst_buffer_if.sv
// IF->ID instruction buffer bus: fetch-side push handshake and decode-side pop handshake.
interface if_id_inst_buffer_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_inst;
   logic [PC_W-1:0]  in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_inst;
   logic [PC_W-1:0]  out_pc;
   logic [CNT_W-1:0] count;

   // Buffer side
   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_inst, out_pc, count
   );

   // Fetch/decode side
   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, count
   );
endinterface

// File: rtl/if_id_inst_buffer.sv
// IF->ID instruction FIFO of {pc, inst} pairs with flush and NOP bubble when empty.
module if_id_inst_buffer #(
   parameter int unsigned     WIDTH = 32,
   parameter int unsigned     PC_W  = 32,
   parameter int unsigned     DEPTH = 4,
   parameter logic [WIDTH-1:0] NOP  = '0
) (
   input logic                clk,
   input logic                rst_n,
   input logic                flush,
   if_id_inst_buffer_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] inst_mem [DEPTH];
   logic [PC_W-1:0]  pc_mem   [DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
   logic [CNT_W-1:0] count_q, count_next;
   logic             in_ready_q, out_valid_q;
   logic [WIDTH-1:0] out_inst_q, head_inst;
   logic [PC_W-1:0]  out_pc_q, head_pc;
   logic             push, pop;

   // Handshakes use registered flags only, so a full buffer refuses even while popping
   assign push = bus.in_valid & in_ready_q;
   assign pop  = out_valid_q & bus.out_ready;

   // Next pointers/count and the head word that will be visible after this edge
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      count_next  = count_q;
      head_inst   = NOP;
      head_pc     = '0;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         wr_ptr_next = wr_ptr + PTR_W'(push);
         rd_ptr_next = rd_ptr + PTR_W'(pop);
         count_next  = count_q + CNT_W'(push) - CNT_W'(pop);
      end
      if (count_next != '0) begin
         // The word being written this edge becomes head when it lands at the new read pointer
         if (push && !flush && (wr_ptr == rd_ptr_next)) begin
            head_inst = bus.in_inst;
            head_pc   = bus.in_pc;
         end else begin
            head_inst = inst_mem[rd_ptr_next];
            head_pc   = pc_mem[rd_ptr_next];
         end
      end
   end

   // Storage array; contents are don't-care after reset or flush
   always_ff @(posedge clk) begin
      if (rst_n && push && !flush) begin
         inst_mem[wr_ptr] <= bus.in_inst;
         pc_mem[wr_ptr]   <= bus.in_pc;
      end
   end

   // Pointer, count and registered output state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_inst_q  <= NOP;
         out_pc_q    <= '0;
      end else begin
         wr_ptr      <= wr_ptr_next;
         rd_ptr      <= rd_ptr_next;
         count_q     <= count_next;
         in_ready_q  <= (count_next != CNT_W'(DEPTH));
         out_valid_q <= (count_next != '0);
         out_inst_q  <= head_inst;
         out_pc_q    <= head_pc;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_inst  = out_inst_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.count     = count_q;

   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));
   a_ptr_gap: assert property (@(posedge clk) disable iff (!rst_n)
      PTR_W'(wr_ptr - rd_ptr) == count_q[PTR_W-1:0]);
endmodule

// File: tb/tb_if_id_inst_buffer.sv
// Scoreboard bench for if_id_inst_buffer: directed IF/ID traffic, cycle-accurate occupancy model.
module tb_if_id_inst_buffer;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned PC_W  = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   if_id_inst_buffer_if #(.WIDTH(WIDTH), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

   if_id_inst_buffer #(.WIDTH(WIDTH), .PC_W(PC_W), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          mcnt   = 0;
   bit          mon_en = 1'b0;
   logic [63:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected-word capture: accepted pushes enter the scoreboard at the edge they happen
   always @(posedge clk) begin
      bit m_push, m_pop;
      if (!rst_n || flush) begin
         exp_q.delete();
         mcnt = 0;
      end else begin
         m_push = bus.in_valid && (mcnt != DEPTH);
         m_pop  = (mcnt != 0) && bus.out_ready;
         if (m_push) exp_q.push_back({bus.in_pc, bus.in_inst});
         mcnt = mcnt + int'(m_push) - int'(m_pop);
      end
   end

   // Monitor: per-cycle flag/count checks and in-order data check on every pop
   always @(negedge clk) begin
      logic [63:0] e;
      if (mon_en) begin
         chk("in_ready", 64'(bus.in_ready), 64'(mcnt != DEPTH));
         chk("out_valid", 64'(bus.out_valid), 64'(mcnt != 0));
         chk("count", 64'(bus.count), 64'(mcnt));
         if (!bus.out_valid) begin
            chk("idle_inst", 64'(bus.out_inst), 64'(NOP));
            chk("idle_pc", 64'(bus.out_pc), 64'h0);
         end else if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got inst 0x%0h expected no output at %0t", bus.out_inst, $time);
            end else begin
               e = exp_q.pop_front();
               chk("sb_inst", 64'(bus.out_inst), 64'(e[31:0]));
               chk("sb_pc", 64'(bus.out_pc), 64'(e[63:32]));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      bus.in_valid = v;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
   endtask

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.out_ready = 1'b0;
      offer(1'b1, 32'h11, 32'h44);

      // Reset with a live offer
      step();
      step();
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_out_inst", 64'(bus.out_inst), 64'h0);
      chk("rst_out_pc", 64'(bus.out_pc), 64'h0);
      chk("rst_count", 64'(bus.count), 64'h0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
      offer(1'b0, 32'h0, 32'h0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step();

      // Single push held under a decode stall
      offer(1'b1, 32'h2008_0005, 32'h0040_0000);
      step();
      offer(1'b0, 32'h0, 32'h0);
      chk("single_valid", 64'(bus.out_valid), 64'h1);
      chk("single_inst", 64'(bus.out_inst), 64'h2008_0005);
      chk("single_pc", 64'(bus.out_pc), 64'h0040_0000);
      chk("single_count", 64'(bus.count), 64'h1);
      for (int i = 0; i < 5; i++) step();
      chk("stall_inst", 64'(bus.out_inst), 64'h2008_0005);
      chk("stall_count", 64'(bus.count), 64'h1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("single_drained", 64'(bus.count), 64'h0);

      // Fill to full, hold a refused word, then drain in order
      for (int i = 1; i <= 4; i++) begin
         offer(1'b1, 32'hA0 + 32'(i), 32'h100 + 32'(4 * i));
         step();
      end
      chk("full_count", 64'(bus.count), 64'h4);
      chk("full_in_ready", 64'(bus.in_ready), 64'h0);
      offer(1'b1, 32'hA5, 32'h114);
      step();
      step();
      chk("full_hold_count", 64'(bus.count), 64'h4);
      bus.out_ready = 1'b1;
      step();
      chk("full_pushpop_count", 64'(bus.count), 64'h3);
      chk("full_pushpop_ready", 64'(bus.in_ready), 64'h1);
      step();
      offer(1'b0, 32'h0, 32'h0);
      chk("a5_taken_count", 64'(bus.count), 64'h3);
      for (int i = 0; i < 4; i++) step();
      bus.out_ready = 1'b0;
      chk("full_drained", 64'(bus.count), 64'h0);
      chk("full_none_lost", 64'(exp_q.size()), 64'h0);

      // Simultaneous push and pop at count=2
      offer(1'b1, 32'hB1, 32'h200);
      step();
      offer(1'b1, 32'hB2, 32'h204);
      step();
      chk("pp_pre_count", 64'(bus.count), 64'h2);
      bus.out_ready = 1'b1;
      offer(1'b1, 32'hB3, 32'h208);
      step();
      chk("pp_count_a", 64'(bus.count), 64'h2);
      chk("pp_head_a", 64'(bus.out_inst), 64'hB2);
      offer(1'b1, 32'hB4, 32'h20C);
      step();
      chk("pp_count_b", 64'(bus.count), 64'h2);
      chk("pp_head_b", 64'(bus.out_inst), 64'hB3);
      offer(1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) step();
      bus.out_ready = 1'b0;
      chk("pp_drained", 64'(exp_q.size()), 64'h0);

      // Flush at count=3 with a pending word
      for (int i = 1; i <= 3; i++) begin
         offer(1'b1, 32'hC0 + 32'(i), 32'h300 + 32'(4 * i));
         step();
      end
      chk("flush_pre_count", 64'(bus.count), 64'h3);
      offer(1'b1, 32'hDEAD, 32'h3F0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      chk("flush_count", 64'(bus.count), 64'h0);
      chk("flush_valid", 64'(bus.out_valid), 64'h0);
      chk("flush_inst", 64'(bus.out_inst), 64'(NOP));
      chk("flush_ready", 64'(bus.in_ready), 64'h1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("flush_still_empty", 64'(bus.out_valid), 64'h0);

      // Streaming with decode always ready, pointers wrap repeatedly
      for (int i = 0; i < 10; i++) begin
         offer(1'b1, 32'h6000 + 32'(i), 32'h2000 + 32'(4 * i));
         step();
         chk("stream_count", 64'(bus.count), 64'h1);
         chk("stream_inst", 64'(bus.out_inst), 64'h6000 + 64'(i));
         chk("stream_pc", 64'(bus.out_pc), 64'h2000 + 64'(4 * i));
      end
      offer(1'b0, 32'h0, 32'h0);
      step();
      chk("stream_end_count", 64'(bus.count), 64'h0);
      chk("stream_none_lost", 64'(exp_q.size()), 64'h0);

      // Reset mid-stream
      bus.out_ready = 1'b0;
      offer(1'b1, 32'hE1, 32'h400);
      step();
      step();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      step();
      rst_n = 1'b1;
      offer(1'b0, 32'h0, 32'h0);
      chk("midrst_count", 64'(bus.count), 64'h0);
      chk("midrst_valid", 64'(bus.out_valid), 64'h0);
      chk("midrst_ready", 64'(bus.in_ready), 64'h1);
      mon_en = 1'b1;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
